// File: rtl/mdc_reorder_out.sv
// mdc_reorder_out: output reorder buffer at the tail of the two-lane MDC FFT.
// Accepts sample pairs in bit-reversed frame order (no input backpressure),
// stores each frame in one of two ping-pong banks, and emits the frame in
// natural order on two lanes with a valid/ready handshake.
// Optional build macro MDC_REORDER_ROUND_SHIFT_EN: applies round-half-up
// arithmetic shift by LOG2N to every real/imag component (1/N scaling for IFFT).
module mdc_reorder_out #(
  parameter int LOG2N = 3,
  parameter int DW    = 64
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          IN_VALID,
  input  logic          IN_SOF,
  input  logic [DW-1:0] D0,
  input  logic [DW-1:0] D1,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] Q0,
  output logic [DW-1:0] Q1,
  output logic          OUT_SOF,
  output logic          OUT_EOF,
  output logic          OVF
);

  localparam int N  = 1 << LOG2N;
  localparam int CW = LOG2N - 1;   // pair counter width (N/2 pairs per frame)
  localparam int HW = DW / 2;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;
  localparam logic [1:0] ST_DRAIN = 2'd3;

  localparam logic [CW-1:0] ZERO_C = {CW{1'b0}};
  localparam logic [CW-1:0] ONE_C  = CW'(1);
  localparam logic [CW-1:0] LAST_C = {CW{1'b1}};

  // Reverse the bit order of a frame index.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = a[LOG2N-1-i];
    end
    return r;
  endfunction

`ifdef MDC_REORDER_ROUND_SHIFT_EN
  localparam logic [HW:0] RND = {{HW{1'b0}}, 1'b1} << (LOG2N - 1);

  // (x + 2**(LOG2N-1)) >>> LOG2N on one component; one guard bit avoids wrap.
  function automatic logic [HW-1:0] rnd_shift(input logic [HW-1:0] x);
    logic [HW:0] sum;
    logic [HW:0] sh;
    sum = {x[HW-1], x} + RND;
    sh  = $signed(sum) >>> LOG2N;
    return sh[HW-1:0];
  endfunction

  // Scale both components of a complex word.
  function automatic logic [DW-1:0] scale_word(input logic [DW-1:0] w);
    return {rnd_shift(w[DW-1:HW]), rnd_shift(w[HW-1:0])};
  endfunction
`endif

  // Two banks of N words, addressed {bank, index}.
  logic [DW-1:0] mem [0:2*N-1];

  logic [1:0][1:0] st_r;
  logic [1:0][1:0] st_nx;
  logic            wr_bank_r;
  logic            rd_bank_r;
  logic            out_bank_r;   // bank the pair in the output register came from
  logic            wr_act_r;     // a frame is being written
  logic [CW-1:0]   wr_cnt_r;
  logic [CW-1:0]   rd_cnt_r;

  logic            loadable_s;
  logic            load_s;
  logic            release_s;
  logic            wr_free_s;
  logic            sof_s;
  logic            wr_restart_s;
  logic            wr_start_s;
  logic            wr_drop_s;
  logic            wr_en_s;
  logic            wr_done_s;
  logic [CW-1:0]   wr_c_s;
  logic [DW-1:0]   rd0_s;
  logic [DW-1:0]   rd1_s;

  // Handshake, bank-availability and write-qualification decode.
  always_comb begin
    loadable_s   = (st_r[rd_bank_r] == ST_FULL) || (st_r[rd_bank_r] == ST_DRAIN);
    load_s       = loadable_s && (!OUT_VALID || OUT_READY);
    release_s    = OUT_VALID && OUT_READY && OUT_EOF;
    // A bank freed at this very edge is already usable by an incoming SOF.
    wr_free_s    = (st_r[wr_bank_r] == ST_EMPTY) || (release_s && (out_bank_r == wr_bank_r));
    sof_s        = IN_VALID && IN_SOF;
    wr_restart_s = sof_s && wr_act_r;
    wr_start_s   = sof_s && !wr_act_r && wr_free_s;
    wr_drop_s    = sof_s && !wr_act_r && !wr_free_s;
    wr_en_s      = wr_restart_s || wr_start_s || (IN_VALID && !IN_SOF && wr_act_r);
    wr_c_s       = sof_s ? ZERO_C : wr_cnt_r;
    wr_done_s    = wr_en_s && (wr_c_s == LAST_C);
  end

  // Next per-bank state: release first, then drain start, then write side.
  always_comb begin
    st_nx = st_r;
    if (release_s) begin
      st_nx[out_bank_r] = ST_EMPTY;
    end else begin
      st_nx = st_nx;
    end
    if (load_s) begin
      st_nx[rd_bank_r] = ST_DRAIN;
    end else begin
      st_nx = st_nx;
    end
    if (wr_done_s) begin
      st_nx[wr_bank_r] = ST_FULL;
    end else if (wr_en_s) begin
      st_nx[wr_bank_r] = ST_FILL;
    end else begin
      st_nx = st_nx;
    end
  end

  // Natural-order read of the pair at rd_cnt, optionally scaled.
  always_comb begin
`ifdef MDC_REORDER_ROUND_SHIFT_EN
    rd0_s = scale_word(mem[{rd_bank_r, rd_cnt_r, 1'b0}]);
    rd1_s = scale_word(mem[{rd_bank_r, rd_cnt_r, 1'b1}]);
`else
    rd0_s = mem[{rd_bank_r, rd_cnt_r, 1'b0}];
    rd1_s = mem[{rd_bank_r, rd_cnt_r, 1'b1}];
`endif
  end

  // Bit-reversed write of the incoming pair into the current write bank.
  always_ff @(posedge CLK) begin
    if (wr_en_s) begin
      mem[{wr_bank_r, bitrev({wr_c_s, 1'b0})}] <= D0;
      mem[{wr_bank_r, bitrev({wr_c_s, 1'b1})}] <= D1;
    end
  end

  // Bank state, write pointer/counter and sticky overflow flag.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      st_r      <= {ST_EMPTY, ST_EMPTY};
      wr_bank_r <= 1'b0;
      wr_act_r  <= 1'b0;
      wr_cnt_r  <= ZERO_C;
      OVF       <= 1'b0;
    end else begin
      st_r <= st_nx;
      OVF  <= OVF | wr_drop_s | wr_restart_s;
      if (wr_done_s) begin
        wr_act_r  <= 1'b0;
        wr_cnt_r  <= ZERO_C;
        wr_bank_r <= ~wr_bank_r;
      end else if (wr_en_s) begin
        wr_act_r <= 1'b1;
        wr_cnt_r <= wr_c_s + ONE_C;
      end
    end
  end

  // Read pointer/counter and the registered output pair.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      rd_bank_r  <= 1'b0;
      rd_cnt_r   <= ZERO_C;
      out_bank_r <= 1'b0;
      OUT_VALID  <= 1'b0;
      Q0         <= {DW{1'b0}};
      Q1         <= {DW{1'b0}};
      OUT_SOF    <= 1'b0;
      OUT_EOF    <= 1'b0;
    end else if (load_s) begin
      Q0         <= rd0_s;
      Q1         <= rd1_s;
      OUT_SOF    <= (rd_cnt_r == ZERO_C);
      OUT_EOF    <= (rd_cnt_r == LAST_C);
      out_bank_r <= rd_bank_r;
      OUT_VALID  <= 1'b1;
      if (rd_cnt_r == LAST_C) begin
        rd_cnt_r  <= ZERO_C;
        rd_bank_r <= ~rd_bank_r;
      end else begin
        rd_cnt_r <= rd_cnt_r + ONE_C;
      end
    end else if (OUT_READY) begin
      OUT_VALID <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mdc_reorder_out.sv
// Directed self-checking bench for mdc_reorder_out (N=8, DW=64).
// Build with MDC_REORDER_ROUND_SHIFT_EN defined to also cover the scaling path.
module tb_mdc_reorder_out;
  localparam int LOG2N = 3;
  localparam int DW    = 64;

  logic          CLK = 1'b0;
  logic          RSTn;
  logic          IN_VALID;
  logic          IN_SOF;
  logic [DW-1:0] D0;
  logic [DW-1:0] D1;
  logic          OUT_VALID;
  logic          OUT_READY;
  logic [DW-1:0] Q0;
  logic [DW-1:0] Q1;
  logic          OUT_SOF;
  logic          OUT_EOF;
  logic          OVF;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [63:0] q0;
    logic [63:0] q1;
    logic        sof;
    logic        eof;
  } pair_t;
  pair_t obs[$];

  // Bit-reversed input order for N=8, written out by hand.
  int order[8] = '{0, 4, 2, 6, 1, 5, 3, 7};

  mdc_reorder_out #(.LOG2N(LOG2N), .DW(DW)) dut (
    .CLK(CLK), .RSTn(RSTn), .IN_VALID(IN_VALID), .IN_SOF(IN_SOF),
    .D0(D0), .D1(D1), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Q0(Q0), .Q1(Q1), .OUT_SOF(OUT_SOF), .OUT_EOF(OUT_EOF), .OVF(OVF)
  );

  always #5 CLK = ~CLK;

  // Record every pair the downstream side accepts.
  always @(negedge CLK) begin
    if (RSTn && OUT_VALID && OUT_READY) begin
      obs.push_back('{q0: Q0, q1: Q1, sof: OUT_SOF, eof: OUT_EOF});
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Sample X[i] of frame f: real = (16f+i)<<16, imag = -real.
  function automatic logic [63:0] mk(input int f, input int i);
    logic [31:0] re;
    re = 32'((f * 16 + i) << 16);
    return {re, -re};
  endfunction

  function automatic logic [31:0] rs(input logic [31:0] x);
    longint v;
    v = longint'($signed(x));
    v = (v + (64'sd1 <<< (LOG2N - 1))) >>> LOG2N;
    return 32'(v);
  endfunction

  // Expected output word for X[i] of frame f.
  function automatic logic [63:0] exp_w(input int f, input int i);
    logic [63:0] w;
    w = mk(f, i);
`ifdef MDC_REORDER_ROUND_SHIFT_EN
    w = {rs(w[63:32]), rs(w[31:0])};
`endif
    return w;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Feed the first n pairs of frame f, SOF on pair 0, no gaps.
  task automatic send_frame(input int f, input int n);
    for (int c = 0; c < n; c++) begin
      IN_VALID = 1'b1;
      IN_SOF   = (c == 0);
      D0       = mk(f, order[2*c]);
      D1       = mk(f, order[2*c+1]);
      tick();
    end
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
  endtask

  task automatic wait_obs(input int n, input int budget);
    int cyc;
    cyc = 0;
    while (obs.size() < n && cyc < budget) begin
      tick();
      cyc++;
    end
    if (obs.size() < n) chk("wait_timeout", 64'(obs.size()), 64'(n));
  endtask

  task automatic check_frame(input int f, input int base);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("f%0d_k%0d_q0", f, k), obs[base+k].q0, exp_w(f, 2*k));
      chk($sformatf("f%0d_k%0d_q1", f, k), obs[base+k].q1, exp_w(f, 2*k+1));
      chk($sformatf("f%0d_k%0d_sof", f, k), 64'(obs[base+k].sof), 64'(k == 0));
      chk($sformatf("f%0d_k%0d_eof", f, k), 64'(obs[base+k].eof), 64'(k == 3));
    end
  endtask

  task automatic do_reset();
    RSTn = 1'b0;
    tick();
    tick();
    RSTn = 1'b1;
    tick();
  endtask

  initial begin
    RSTn      = 1'b0;
    IN_VALID  = 1'b0;
    IN_SOF    = 1'b0;
    D0        = 64'h0;
    D1        = 64'h0;
    OUT_READY = 1'b1;
    repeat (3) tick();
    RSTn = 1'b1;

    // Reset / idle
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("idle_valid", 64'(OUT_VALID), 64'h0);
      chk("idle_q", Q0 | Q1, 64'h0);
      chk("idle_ovf", 64'(OVF), 64'h0);
    end

    // Reorder with exact latency, OUT_READY=1
    obs.delete();
    send_frame(1, 4);
    chk("lat_valid_e", 64'(OUT_VALID), 64'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk($sformatf("ro_valid_k%0d", k), 64'(OUT_VALID), 64'h1);
      chk($sformatf("ro_q0_k%0d", k), Q0, exp_w(1, 2*k));
      chk($sformatf("ro_q1_k%0d", k), Q1, exp_w(1, 2*k+1));
      chk($sformatf("ro_sof_k%0d", k), 64'(OUT_SOF), 64'(k == 0));
      chk($sformatf("ro_eof_k%0d", k), 64'(OUT_EOF), 64'(k == 3));
    end
    tick();
    chk("ro_valid_after", 64'(OUT_VALID), 64'h0);

    // Backpressure mid-frame
    obs.delete();
    send_frame(2, 4);
    wait_obs(2, 20);
    OUT_READY = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", 64'(OUT_VALID), 64'h1);
      chk("bp_q0", Q0, exp_w(2, 4));
      chk("bp_q1", Q1, exp_w(2, 5));
    end
    OUT_READY = 1'b1;
    wait_obs(4, 20);
    repeat (5) tick();
    chk("bp_count", 64'(obs.size()), 64'd4);
    if (obs.size() >= 4) check_frame(2, 0);

    // Overflow: three frames while stalled
    obs.delete();
    chk("ovf_pre", 64'(OVF), 64'h0);
    OUT_READY = 1'b0;
    send_frame(3, 4);
    send_frame(4, 4);
    chk("ovf_after_f4", 64'(OVF), 64'h0);
    send_frame(5, 4);
    chk("ovf_after_f5", 64'(OVF), 64'h1);
    chk("ovf_valid_held", 64'(OUT_VALID), 64'h1);
    OUT_READY = 1'b1;
    wait_obs(8, 40);
    repeat (10) tick();
    chk("ovf_count", 64'(obs.size()), 64'd8);
    if (obs.size() >= 8) begin
      check_frame(3, 0);
      check_frame(4, 4);
    end

    // Reset mid-frame, then mid-frame SOF restart
    send_frame(8, 2);
    RSTn = 1'b0;
    #1;
    chk("rst_async_ovf", 64'(OVF), 64'h0);
    chk("rst_async_valid", 64'(OUT_VALID), 64'h0);
    tick();
    RSTn = 1'b1;
    tick();
    obs.delete();
    send_frame(6, 2);
    chk("msof_ovf_pre", 64'(OVF), 64'h0);
    send_frame(7, 4);
    chk("msof_ovf", 64'(OVF), 64'h1);
    wait_obs(4, 20);
    repeat (10) tick();
    chk("msof_count", 64'(obs.size()), 64'd4);
    if (obs.size() >= 4) check_frame(7, 0);

`ifdef MDC_REORDER_ROUND_SHIFT_EN
    // Rounding/shift corner values (N=8)
    do_reset();
    obs.delete();
    for (int c = 0; c < 4; c++) begin
      IN_VALID = 1'b1;
      IN_SOF   = (c == 0);
      D0       = (c == 0) ? 64'h00080000_00000004 : 64'h0;
      D1       = (c == 0) ? 64'hFFFFFFFB_00000000 : 64'h0;
      tick();
    end
    IN_VALID = 1'b0;
    IN_SOF   = 1'b0;
    wait_obs(4, 20);
    if (obs.size() >= 4) begin
      chk("rs_x0", obs[0].q0, 64'h00010000_00000001);
      chk("rs_x1", obs[0].q1, 64'h00000000_00000000);
      chk("rs_x4", obs[2].q0, 64'hFFFFFFFF_00000000);
    end
`else
    do_reset();
    chk("final_ovf_cleared", 64'(OVF), 64'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
